cpu_display_scan_ctrl: RTL
==========================

# cpu_display_scan_ctrl

Avalon-MM slave that drives a bank of four time-multiplexed 7-segment digits from a single shared segment bus. Software writes four hex nibbles and a control word; an internal prescaler and scan state machine take turns driving each digit, with a blanking gap between digits to suppress ghosting. It sits beside the existing display PIO slaves on the CPU system interconnect and replaces one-PIO-per-digit wiring on boards with common segment lines.

## Interface
- `DEFAULT_PRESCALE`, 16'd49999, reset value of the PRESCALE register (dwell length minus 1, in clocks)
- `BLANK_CYCLES`, 4, clocks of blanking between digits; legal range 1..255
- `clk`  in  1  system clock; the block has one clock
- `reset_n`  in  1  reset, asynchronous and active-low
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data; combinational, zero wait states, unused bits 0
- `seg_out`  out  7  segments, active-low; bit0 = a … bit6 = g; registered
- `digit_en`  out  4  digit enables, active-high, one-hot or zero; registered

## Operation
- Write occurs when `chipselect && !write_n`, on that clk edge.
- Address 0 DATA (R/W): bits[15:0]; digit i = bits[4i+3:4i]. Bits[31:16] are ignored on write and read back as 0.
- Address 1 CONTROL (R/W): bit0 ENABLE; bits[7:4] BLANK_MASK, where 1 forces digit i off. Other bits are 0.
- Address 2 PRESCALE (R/W): bits[15:0].
- Address 3 STATUS (RO): bits[1:0] current digit index; bit2 = 1 in BLANK; bit3 = 1 in SHOW. Writes are ignored.
- Hex decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- FSM states:
  - IDLE: idx = 0, `digit_en` = 0, `seg_out` = 7F. Goes to BLANK when ENABLE = 1.
  - BLANK: `digit_en` = 0, `seg_out` = 7F, lasts BLANK_CYCLES clocks, then goes to SHOW.
  - SHOW: `digit_en` = 1<<idx and `seg_out` = decode(digit idx), except when BLANK_MASK[idx] = 1, which gives `digit_en` = 0 and `seg_out` = 7F. Lasts latched PRESCALE+1 clocks, then idx = (idx+1) mod 4, wrapping 3→0, and goes to BLANK.
- PRESCALE is latched into the dwell counter on SHOW entry. A write during SHOW affects only the next SHOW.
- A DATA or CONTROL write during SHOW takes effect on the displayed outputs on the following clk edge, within the same dwell.
- ENABLE cleared in any state: next edge → IDLE, idx = 0, outputs off. Counters are cleared.
- ENABLE set and cleared in the same cycle is impossible, because a single register write decides it.
- PRESCALE = 0: SHOW lasts exactly 1 clock.

## Timing
- Reset (async assert) forces:
  - DATA = 0, CONTROL = 0, PRESCALE = DEFAULT_PRESCALE
  - state IDLE, idx 0
  - `seg_out` = 7F, `digit_en` = 0
  - `readdata` = 0 for address 0, 1 and 3; DEFAULT_PRESCALE for address 2
- Reset deassertion mid-scan restarts from IDLE. No partial dwell resumes.
- The output registers and the state update on the same edge. Outputs reflect the new state in the cycle after the transition edge.
- ENABLE write at edge k:
  - edge k+1 enters BLANK, idx 0
  - edge k+1+BLANK_CYCLES enters SHOW, so digit 0 is lit from that edge
- Full scan period = 4 × (BLANK_CYCLES + PRESCALE + 1) clocks.
- `readdata` follows `address` combinationally. A read in the same cycle as a write returns the old value.
- The `digit_en` one-hot invariant: at most one bit set in any cycle. `digit_en` ≠ 0 only in SHOW.

## Test plan
- Reset, then read addresses 0–3 → 0, 0, 0x0000C34F, 0. `seg_out` = 7F and `digit_en` = 0 held with no writes.
- PRESCALE = 3, DATA = 0x1234, CONTROL = 1:
  - `digit_en` sequence is 0 ×4, 0001 ×4, 0 ×4, 0010 ×4, …, 1000 ×4, then wraps to 0001
  - `seg_out` during each SHOW = 19, 30, 24, 79 (digits 0–3)
- BLANK_MASK = 0b0100, same setup → `digit_en` never equals 0100. `seg_out` = 7F during digit 2's SHOW, and the period is unchanged at 32 clocks.
- Mid-dwell writes during SHOW of digit 1:
  - DATA write 0x00F0 → `seg_out` becomes 0E next edge
  - PRESCALE write 0 → current dwell still 4 clocks; the next SHOW lasts 1 clock
- Clear ENABLE during SHOW of digit 3 → next edge: `digit_en` 0, STATUS = 0. Re-enable restarts at digit 0 after 4 blank clocks.
- Assert `reset_n` low mid-SHOW → outputs off immediately (asynchronous). Registers return to their reset values, and the scan is idle after release.

Source files
------------

// File: rtl/cpu_display_scan_ctrl.sv
// Avalon-MM slave scanning four multiplexed 7-segment digits over a shared segment bus,
// with a blanking gap between digits to suppress ghosting.
module cpu_display_scan_ctrl #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd49999,
    parameter int unsigned BLANK_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_en
);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);

    logic [15:0] data_q;
    logic        enable_q;
    logic [3:0]  mask_q;
    logic [15:0] prescale_q;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  den_q, den_d;
    logic        lit;
    logic        wr;
    logic        unused_wd;

    assign wr        = chipselect && !write_n;
    assign unused_wd = ^{writedata[31:16], writedata[3:1]};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= 16'h0000;
            enable_q   <= 1'b0;
            mask_q     <= 4'h0;
            prescale_q <= DEFAULT_PRESCALE;
        end else if (wr) begin
            unique case (address)
                2'd0: data_q <= writedata[15:0];
                2'd1: begin
                    enable_q <= writedata[0];
                    mask_q   <= writedata[7:4];
                end
                2'd2: prescale_q <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Both dwell phases count down to zero; SHOW length is latched from PRESCALE on entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable_q) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    idx_d   = 2'd0;
                    cnt_d   = BlankLast;
                end
                StBlank: begin
                    if (cnt_q == 16'h0000) begin
                        state_d = StShow;
                        cnt_d   = prescale_q;
                    end else begin
                        cnt_d = cnt_q - 16'h0001;
                    end
                end
                StShow: begin
                    if (cnt_q == 16'h0000) begin
                        state_d = StBlank;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = BlankLast;
                    end else begin
                        cnt_d = cnt_q - 16'h0001;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 2'd0;
                    cnt_d   = 16'h0000;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_comb begin
        lit   = (state_d == StShow) && !mask_q[idx_d];
        seg_d = 7'h7F;
        den_d = 4'h0;
        if (lit) begin
            seg_d = hex7(data_q[{idx_d, 2'b00} +: 4]);
            den_d = 4'b0001 << idx_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 16'h0000;
            seg_q   <= 7'h7F;
            den_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            den_q   <= den_d;
        end
    end

    assign seg_out  = seg_q;
    assign digit_en = den_q;

    always_comb begin
        readdata = 32'h0000_0000;
        unique case (address)
            2'd0: readdata = {16'h0000, data_q};
            2'd1: readdata = {24'h000000, mask_q, 3'b000, enable_q};
            2'd2: readdata = {16'h0000, prescale_q};
            2'd3: readdata = {28'h0000000, state_q == StShow, state_q == StBlank, idx_q};
            default: readdata = 32'h0000_0000;
        endcase
    end

endmodule
